// File: rtl/imem_loader.sv
// imem_loader: byte-stream boot loader feeding the instruction memory write port.
// Stream layout: LEN_LO, LEN_HI (word count N, little-endian), then N*4 data bytes
// with each word sent least-significant byte first. When the macro CHECKSUM_EN is
// defined, the data is followed by one checksum byte, the XOR of all data bytes.
// The core is held at PC 0 until the whole image has been written.
module imem_loader #(
  parameter int ADDR_WIDTH = 8
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  in_valid,
  input  logic [7:0]            in_data,
  output logic                  in_ready,
  output logic                  we,
  output logic [ADDR_WIDTH-1:0] waddr,
  output logic [31:0]           wdata,
  output logic                  core_hold,
  output logic                  done,
  output logic                  error,
  output logic [ADDR_WIDTH:0]   words_loaded
);

  // Capacity in words, widened so it can be compared against the 16-bit header.
  localparam logic [16:0] DEPTH = 17'(1) << ADDR_WIDTH;

  typedef enum logic [2:0] {
    S_LEN0 = 3'd0,
    S_LEN1 = 3'd1,
    S_DATA = 3'd2,
`ifdef CHECKSUM_EN
    S_CHK  = 3'd3,
`endif
    S_DONE = 3'd4,
    S_ERR  = 3'd5
  } state_t;

  state_t                state_q, state_d;
  logic [7:0]            len_lo_q, len_lo_d;
  logic [15:0]           n_q, n_d;
  logic [1:0]            cnt_q, cnt_d;
  logic [23:0]           pack_q, pack_d;
  logic                  we_q, we_d;
  logic [ADDR_WIDTH-1:0] waddr_q, waddr_d;
  logic [31:0]           wdata_q, wdata_d;
  logic [ADDR_WIDTH:0]   wl_q, wl_d;
  logic                  done_q, done_d;
`ifdef CHECKSUM_EN
  logic [7:0]            xor_q, xor_d;
`endif

  logic        take;
  logic [15:0] len_w;
  logic [16:0] next_count;

  assign take       = in_valid & in_ready;
  assign len_w      = {in_data, len_lo_q};
  // Number of words written once the word currently being completed lands.
  assign next_count = 17'(wl_q) + 17'd1;

  // Bytes are accepted in every state except the terminal ones.
  assign in_ready     = (state_q != S_DONE) && (state_q != S_ERR);
  assign we           = we_q;
  assign waddr        = waddr_q;
  assign wdata        = wdata_q;
  assign done         = done_q;
  assign error        = (state_q == S_ERR);
  // Core is released only once done is visible, i.e. after the last strobe.
  assign core_hold    = ~done_q;
  assign words_loaded = wl_q;

  // State and datapath registers; reset restarts the load without touching memory.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= S_LEN0;
      len_lo_q <= '0;
      n_q      <= '0;
      cnt_q    <= '0;
      pack_q   <= '0;
      we_q     <= 1'b0;
      waddr_q  <= '0;
      wdata_q  <= '0;
      wl_q     <= '0;
      done_q   <= 1'b0;
`ifdef CHECKSUM_EN
      xor_q    <= '0;
`endif
    end else begin
      state_q  <= state_d;
      len_lo_q <= len_lo_d;
      n_q      <= n_d;
      cnt_q    <= cnt_d;
      pack_q   <= pack_d;
      we_q     <= we_d;
      waddr_q  <= waddr_d;
      wdata_q  <= wdata_d;
      wl_q     <= wl_d;
      done_q   <= done_d;
`ifdef CHECKSUM_EN
      xor_q    <= xor_d;
`endif
    end
  end

  // Next-state logic: header parsing, byte packing, write strobe and termination.
  always_comb begin
    state_d  = state_q;
    len_lo_d = len_lo_q;
    n_d      = n_q;
    cnt_d    = cnt_q;
    pack_d   = pack_q;
    we_d     = 1'b0;
    waddr_d  = waddr_q;
    wdata_d  = wdata_q;
    // The word index advances at the end of the strobe cycle.
    wl_d     = wl_q + {{ADDR_WIDTH{1'b0}}, we_q};
    done_d   = done_q;
`ifdef CHECKSUM_EN
    xor_d    = xor_q;
`endif

    case (state_q)
      S_LEN0: begin
        if (take) begin
          len_lo_d = in_data;
          state_d  = S_LEN1;
        end
      end

      S_LEN1: begin
        if (take) begin
          if ((len_w == 16'd0) || ({1'b0, len_w} > DEPTH)) begin
            state_d = S_ERR;
          end else begin
            n_d     = len_w;
            cnt_d   = 2'd0;
            state_d = S_DATA;
`ifdef CHECKSUM_EN
            xor_d   = 8'd0;
`endif
          end
        end
      end

      S_DATA: begin
        if (take) begin
          cnt_d = cnt_q + 2'd1;
`ifdef CHECKSUM_EN
          xor_d = xor_q ^ in_data;
`endif
          case (cnt_q)
            2'd0: pack_d[7:0]   = in_data;
            2'd1: pack_d[15:8]  = in_data;
            2'd2: pack_d[23:16] = in_data;
            default: begin
              // Fourth byte completes the word: strobe it out next cycle.
              we_d    = 1'b1;
              wdata_d = {in_data, pack_q};
              waddr_d = wl_q[ADDR_WIDTH-1:0];
              if (next_count == {1'b0, n_q}) begin
`ifdef CHECKSUM_EN
                state_d = S_CHK;
`else
                state_d = S_DONE;
`endif
              end
            end
          endcase
        end
      end

`ifdef CHECKSUM_EN
      S_CHK: begin
        if (take) begin
          state_d = (in_data == xor_q) ? S_DONE : S_ERR;
        end
      end
`endif

      // done rises one cycle after entry, which is after the final strobe.
      S_DONE: done_d = 1'b1;

      S_ERR: ;

      default: state_d = S_ERR;
    endcase
  end

endmodule

// File: tb/tb_imem_loader.sv
// Scoreboard bench for imem_loader: stimulus pushes expected memory writes into a
// queue, a monitor pops and compares on every write strobe.
module tb_imem_loader;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  // Default-size instance
  logic        in_valid_a = 1'b0;
  logic [7:0]  in_data_a  = 8'h00;
  logic        in_ready_a, we_a, core_hold_a, done_a, error_a;
  logic [7:0]  waddr_a;
  logic [31:0] wdata_a;
  logic [8:0]  wl_a;

  // Small instance for the capacity boundary
  logic        in_valid_b = 1'b0;
  logic [7:0]  in_data_b  = 8'h00;
  logic        in_ready_b, we_b, core_hold_b, done_b, error_b;
  logic [3:0]  waddr_b;
  logic [31:0] wdata_b;
  logic [4:0]  wl_b;

  imem_loader #(.ADDR_WIDTH(8)) dut_a (
    .clk(clk), .rst(rst), .in_valid(in_valid_a), .in_data(in_data_a),
    .in_ready(in_ready_a), .we(we_a), .waddr(waddr_a), .wdata(wdata_a),
    .core_hold(core_hold_a), .done(done_a), .error(error_a), .words_loaded(wl_a)
  );

  imem_loader #(.ADDR_WIDTH(4)) dut_b (
    .clk(clk), .rst(rst), .in_valid(in_valid_b), .in_data(in_data_b),
    .in_ready(in_ready_b), .we(we_b), .waddr(waddr_b), .wdata(wdata_b),
    .core_hold(core_hold_b), .done(done_b), .error(error_b), .words_loaded(wl_b)
  );

  int chk_cnt  = 0;
  int pass_cnt = 0;

  typedef struct {
    logic [7:0]  addr;
    logic [31:0] data;
  } wr_t;
  wr_t exp_q[$];

  logic [31:0] mem [256];

  function automatic void chk(string name, logic [31:0] act, logic [31:0] exp);
    chk_cnt++;
    if (act === exp) pass_cnt++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
  endfunction

  // Monitor: every write strobe must match the oldest expected write.
  always @(negedge clk) begin
    if (!rst && we_a) begin
      if (exp_q.size() == 0) begin
        chk_cnt++;
        $display("FAIL unexpected_write_a: got addr %0d data 0x%0h, expected no write",
                 waddr_a, wdata_a);
      end else begin
        wr_t e;
        e = exp_q.pop_front();
        chk("wr_addr", {24'd0, waddr_a}, {24'd0, e.addr});
        chk("wr_data", wdata_a, e.data);
      end
      mem[waddr_a] = wdata_a;
    end
    if (!rst && we_b) begin
      chk_cnt++;
      $display("FAIL unexpected_write_b: got addr %0d data 0x%0h, expected no write",
               waddr_b, wdata_b);
    end
  end

  task automatic push_exp(input logic [7:0] addr, input logic [31:0] data);
    wr_t e;
    e.addr = addr;
    e.data = data;
    exp_q.push_back(e);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    in_valid_a = 1'b0;
    in_valid_b = 1'b0;
    rst = 1'b1;
    tick();
    rst = 1'b0;
  endtask

  task automatic send_a(input logic [7:0] b, input int gap);
    in_valid_a = 1'b0;
    repeat (gap) tick();
    in_valid_a = 1'b1;
    in_data_a  = b;
    tick();
    in_valid_a = 1'b0;
  endtask

  task automatic send_b(input logic [7:0] b);
    in_valid_b = 1'b1;
    in_data_b  = b;
    tick();
    in_valid_b = 1'b0;
  endtask

  logic [7:0] s_prog [10] = '{8'h02, 8'h00, 8'h13, 8'h05, 8'h10, 8'h00,
                              8'h93, 8'h05, 8'h20, 8'h00};
  logic [7:0] s_beef [4]  = '{8'hEF, 8'hBE, 8'hAD, 8'hDE};

  initial begin
    for (int i = 0; i < 256; i++) mem[i] = 32'd0;
    tick();
    do_reset();

    // Reset values
    chk("rst_in_ready",  {31'd0, in_ready_a},  32'd1);
    chk("rst_we",        {31'd0, we_a},        32'd0);
    chk("rst_waddr",     {24'd0, waddr_a},     32'd0);
    chk("rst_wdata",     wdata_a,              32'd0);
    chk("rst_core_hold", {31'd0, core_hold_a}, 32'd1);
    chk("rst_done",      {31'd0, done_a},      32'd0);
    chk("rst_error",     {31'd0, error_a},     32'd0);
    chk("rst_words",     {23'd0, wl_a},        32'd0);

    // Two-word program, back-to-back bytes
    push_exp(8'd0, 32'h0010_0513);
    push_exp(8'd1, 32'h0020_0593);
    for (int i = 0; i < 10; i++) send_a(s_prog[i], 0);
`ifdef CHECKSUM_EN
    send_a(8'hB0, 0);
`endif
    chk("t1_done_early", {31'd0, done_a}, 32'd0);
    tick();
    chk("t1_done",      {31'd0, done_a},      32'd1);
    chk("t1_core_hold", {31'd0, core_hold_a}, 32'd0);
    chk("t1_words",     {23'd0, wl_a},        32'd2);
    chk("t1_in_ready",  {31'd0, in_ready_a},  32'd0);
    chk("t1_pending",   exp_q.size(),         32'd0);
    send_a(8'h55, 0);
    chk("t1_words_after_extra", {23'd0, wl_a}, 32'd2);

    // Zero-length header
    do_reset();
    send_a(8'h00, 0);
    send_a(8'h00, 0);
    chk("t2_error",     {31'd0, error_a},     32'd1);
    chk("t2_in_ready",  {31'd0, in_ready_a},  32'd0);
    chk("t2_core_hold", {31'd0, core_hold_a}, 32'd1);
    send_a(8'h13, 0);
    chk("t2_words",     {23'd0, wl_a},        32'd0);
    chk("t2_done",      {31'd0, done_a},      32'd0);

    // Capacity boundary on the 16-word instance: 17 rejected, 16 accepted
    do_reset();
    send_b(8'h11);
    send_b(8'h00);
    chk("t3_error",     {31'd0, error_b},     32'd1);
    chk("t3_words",     {27'd0, wl_b},        32'd0);
    chk("t3_core_hold", {31'd0, core_hold_b}, 32'd1);
    do_reset();
    send_b(8'h10);
    send_b(8'h00);
    chk("t3_n16_error", {31'd0, error_b},     32'd0);
    chk("t3_n16_ready", {31'd0, in_ready_b},  32'd1);

    // Single word with random gaps between bytes
    do_reset();
    push_exp(8'd0, 32'hDEAD_BEEF);
    send_a(8'h01, 0);
    send_a(8'h00, 0);
    for (int i = 0; i < 4; i++) send_a(s_beef[i], $urandom_range(0, 5));
`ifdef CHECKSUM_EN
    send_a(8'h22, $urandom_range(0, 5));
`endif
    tick();
    chk("t4_done",    {31'd0, done_a}, 32'd1);
    chk("t4_words",   {23'd0, wl_a},   32'd1);
    chk("t4_pending", exp_q.size(),    32'd0);

    // Reset after 6 of 8 data bytes, then reload
    do_reset();
    mem[0] = 32'd0;
    mem[1] = 32'd0;
    push_exp(8'd0, 32'h0010_0513);
    for (int i = 0; i < 8; i++) send_a(s_prog[i], 0);
    tick();
    chk("t5_partial_words", {23'd0, wl_a}, 32'd1);
    chk("t5_partial_pending", exp_q.size(), 32'd0);
    do_reset();
    chk("t5_rst_core_hold", {31'd0, core_hold_a}, 32'd1);
    chk("t5_rst_words",     {23'd0, wl_a},        32'd0);
    chk("t5_mem0_kept",     mem[0],               32'h0010_0513);
    chk("t5_mem1_unwritten", mem[1],              32'd0);
    push_exp(8'd0, 32'h0010_0513);
    push_exp(8'd1, 32'h0020_0593);
    for (int i = 0; i < 10; i++) send_a(s_prog[i], 0);
`ifdef CHECKSUM_EN
    send_a(8'hB0, 0);
`endif
    tick();
    chk("t5_done",  {31'd0, done_a}, 32'd1);
    chk("t5_words", {23'd0, wl_a},   32'd2);
    chk("t5_mem1",  mem[1],          32'h0020_0593);

`ifdef CHECKSUM_EN
    // Checksum accepted and rejected
    do_reset();
    push_exp(8'd0, 32'h0804_0201);
    send_a(8'h01, 0); send_a(8'h00, 0);
    send_a(8'h01, 0); send_a(8'h02, 0); send_a(8'h04, 0); send_a(8'h08, 0);
    send_a(8'h0F, 0);
    tick();
    chk("t6_good_done",  {31'd0, done_a},  32'd1);
    chk("t6_good_error", {31'd0, error_a}, 32'd0);
    do_reset();
    push_exp(8'd0, 32'h0804_0201);
    send_a(8'h01, 0); send_a(8'h00, 0);
    send_a(8'h01, 0); send_a(8'h02, 0); send_a(8'h04, 0); send_a(8'h08, 0);
    send_a(8'h0E, 0);
    tick();
    chk("t6_bad_error",     {31'd0, error_a},     32'd1);
    chk("t6_bad_core_hold", {31'd0, core_hold_a}, 32'd1);
    chk("t6_bad_done",      {31'd0, done_a},      32'd0);
`endif

    repeat (3) tick();
    chk("final_pending", exp_q.size(), 32'd0);
    $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
    $finish;
  end

endmodule
